// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and
// parity-select encodings. Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 7;
  localparam int unsigned FRAME_BITS = 10;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Ports: clk, rst_n (async active-low, flops reset to 1 = idle line),
//        d (async input), q (synchronised output).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + 7 data bits (LSB first) + parity + stop, sampled
// at mid-bit using a baud counter of CLKS_PER_BIT clk cycles per bit.
// Ports: clk, rst_n (async active-low), rxd (serial in, idle high),
//        p_s (0 = even, 1 = odd parity, latched at start detection),
//        dout (received data), rx_valid (1-cycle frame-complete pulse),
//        parity_err / frame_err (status of last frame), busy (not IDLE).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       p_s,
  output logic [6:0] dout,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_e       state, state_nxt;
  logic            rxs, rxs_prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [6:0]      data_q, data_nxt;
  logic            ps_q, ps_nxt;
  logic            par_pend, par_pend_nxt;
  logic [6:0]      dout_nxt;
  logic            rx_valid_nxt, parity_err_nxt, frame_err_nxt;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    idx_nxt        = idx;
    data_nxt       = data_q;
    ps_nxt         = ps_q;
    par_pend_nxt   = par_pend;
    dout_nxt       = dout;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;
    rx_valid_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        // Edge, not level: a line held low cannot retrigger
        if (rxs_prev && !rxs) begin
          state_nxt    = S_START;
          ps_nxt       = p_s;
          par_pend_nxt = 1'b0;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt       = '0;
          data_nxt[idx] = rxs;
          if (idx == IDX_LAST) state_nxt = S_PARITY;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt      = '0;
          par_pend_nxt = (rxs != ((^data_q) ^ (ps_q == PAR_ODD)));
          state_nxt    = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          state_nxt      = S_IDLE;
          dout_nxt       = data_q;
          parity_err_nxt = par_pend;
          frame_err_nxt  = !rxs;
          rx_valid_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_prev   <= 1'b1;
      cnt        <= '0;
      idx        <= '0;
      data_q     <= '0;
      ps_q       <= 1'b0;
      par_pend   <= 1'b0;
      dout       <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rxs_prev   <= rxs;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      data_q     <= data_nxt;
      ps_q       <= ps_nxt;
      par_pend   <= par_pend_nxt;
      dout       <= dout_nxt;
      rx_valid   <= rx_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT = 16): frames are driven
// bit by bit, expected results queued at drive time and compared on rx_valid.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       p_s;
  logic [6:0] dout;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   nvalid      = 0;
  int   npushed     = 0;
  bit   rv_prev     = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .p_s        (p_s),
    .dout       (dout),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic good_par(input logic [6:0] d, input logic ps);
    return (^d) ^ ps;
  endfunction

  // Scoreboard consumer: every rx_valid pops one expected frame
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      nvalid++;
      if (rv_prev) check_val("valid_width", 32'd2, 32'd1);
      if (sb.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("dout", 32'(dout), 32'(e.d));
        check_val("parity_err", 32'(parity_err), 32'(e.pe));
        check_val("frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
    rv_prev = (rx_valid === 1'b1);
  end

  task automatic drive_bits(input logic [9:0] frame, input int nbits, input bit flip_ps);
    for (int i = 0; i < nbits; i++) begin
      rxd = frame[i];
      if (i == 1 && flip_ps) p_s = ~p_s;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop, input bit flip_ps);
    exp_t e;
    e.d  = d;
    e.pe = (par != good_par(d, p_s));
    e.fe = ~stop;
    sb.push_back(e);
    npushed++;
    drive_bits({stop, par, d, 1'b0}, 10, flip_ps);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dout"}, 32'(dout), 32'd0);
    check_val({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check_val({tag, "_perr"}, 32'(parity_err), 32'd0);
    check_val({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    p_s   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Even parity, clean frame; outputs must hold afterwards
    p_s = 1'b0;
    send_frame(7'h55, 1'b0, 1'b1, 1'b0);
    idle_bits(3);
    check_val("dout_hold", 32'(dout), 32'h55);

    // Odd parity: wrong then right parity bit
    p_s = 1'b1;
    send_frame(7'h55, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    send_frame(7'h55, 1'b1, 1'b1, 1'b0);
    idle_bits(2);

    // p_s toggled mid-frame must not affect the latched selection
    p_s = 1'b1;
    send_frame(7'h12, good_par(7'h12, 1'b1), 1'b1, 1'b1);
    idle_bits(2);

    // Frame error, then line held low: no retrigger
    p_s = 1'b0;
    send_frame(7'h3A, good_par(7'h3A, 1'b0), 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check_val("held_low_busy", 32'(busy), 32'd0);
    check_val("held_low_ferr", 32'(frame_err), 32'd1);
    idle_bits(2);

    // 4-cycle low glitch: half-bit of busy, then back to idle
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check_val("glitch_busy", 32'(busy), 32'd1);
    repeat (16) @(negedge clk);
    check_val("glitch_idle", 32'(busy), 32'd0);
    idle_bits(2);

    // Back-to-back frames, no idle gap
    p_s = 1'b0;
    send_frame(7'h01, good_par(7'h01, 1'b0), 1'b1, 1'b0);
    send_frame(7'h7F, good_par(7'h7F, 1'b0), 1'b1, 1'b0);
    idle_bits(2);

    // Reset during data bit 3: partial frame discarded
    drive_bits({1'b1, good_par(7'h2C, 1'b0), 7'h2C, 1'b0}, 4, 1'b0);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midframe_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(7'h2C, good_par(7'h2C, 1'b0), 1'b1, 1'b0);
    idle_bits(2);

    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    check_val("valid_count", 32'(nvalid), 32'(npushed));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-005 Port: p_s  input  1  parity select: 0 = even parity, 1 = odd parity (same encoding as the transmitter).
REQ-006 Port: dout  output  7  received data, bit 0 first on the line.
REQ-007 Port: rx_valid  output  1  one-cycle pulse when a frame completes.
REQ-008 Port: parity_err  output  1  parity mismatch on the last completed frame.
REQ-009 Port: frame_err  output  1  stop bit sampled low on the last completed frame.
REQ-010 Port: busy  output  1  high in every state except IDLE.

Function
REQ-011 Frame format: start bit (0), 7 data bits LSB first, 1 parity bit, 1 stop bit (1); 10 bit times in total.
REQ-012 Synchronisation: rxd passes through a 2-flop synchroniser, initialised high; all logic uses the synchronised value rxs.
REQ-013 Start detection: in IDLE, a falling edge on rxs (previous sample 1, current sample 0) enters START and clears the baud counter.
- A line held low does not retrigger.
REQ-014 START: sample rxs at count CLKS_PER_BIT/2 - 1 (integer division).
- rxs = 1: false start; return to IDLE; no flags or outputs change.
- rxs = 0: go to DATA with bit index 0.
REQ-015 Sampling: every later sample falls CLKS_PER_BIT clk cycles after the previous one, so each sample is at mid-bit.
REQ-016 DATA: each sample is shifted into bit[index]; index counts 0..6; after index 6 the state goes to PARITY.
REQ-017 PARITY: sample the parity bit.
- Expected parity = XOR of the 7 data bits, inverted when the latched p_s = 1.
- A mismatch sets the pending parity error; the state goes to STOP.
REQ-018 STOP: sample the stop bit; rxs = 0 sets the pending frame error; the state returns to IDLE in the same cycle.
- A new falling edge can then be detected immediately (back-to-back frames).
REQ-019 Output timing: on the clk edge after the stop sample, all of the following happen together:
- dout is loaded.
- parity_err and frame_err are loaded.
- rx_valid pulses high for exactly 1 cycle.
REQ-020 Output hold: dout, parity_err and frame_err hold their values until the next rx_valid pulse.
- Frames with errors still assert rx_valid and update dout.
REQ-021 p_s latch: p_s is captured on start detection; changing p_s mid-frame has no effect on the current frame.
REQ-022 Baud counter: width is ceil(log2(CLKS_PER_BIT)); it wraps to 0 at each sample point; no overflow is permitted.
REQ-023 States: IDLE, START, DATA, PARITY, STOP; any illegal encoding goes to IDLE on the next clk.

Reset
REQ-024 While rst_n = 0, the following values hold regardless of clk:
- State = IDLE; counters = 0; synchroniser flops = 1.
- dout = 0; rx_valid = 0; parity_err = 0; frame_err = 0; busy = 0.
REQ-025 Reset mid-frame discards the partial frame; no rx_valid is produced for it.
REQ-026 After rst_n deasserts, a frame is received correctly only if its start edge occurs at least 2 clk cycles after deassertion.

Structure
REQ-027 Shared package uart_pkg holds the following, reused by the transmitter:
- Receiver state encoding.
- DATA_BITS = 7 and FRAME_BITS = 10.
- Parity-select encodings PAR_EVEN = 0 and PAR_ODD = 1.
REQ-028 Sub-module uart_rx_sync: 2-flop synchroniser with asynchronous active-low reset to 1; all other logic stays in uart_rx.

Verification (CLKS_PER_BIT = 16)
REQ-029 Even-parity frame: p_s = 0, send data 7'h55 with parity 0 and stop 1.
- Expected: rx_valid pulses once; dout = 7'h55; parity_err = 0; frame_err = 0.
REQ-030 Odd-parity error: p_s = 1, send 7'h55 with parity 0.
- Expected: dout = 7'h55; parity_err = 1.
- Then send 7'h55 with parity 1; expected: parity_err = 0.
REQ-031 Frame error and edge check: send 7'h3A with stop bit 0, then hold the line low for 20 bit times.
- Expected: frame_err = 1 and rx_valid pulses once.
- No further frame is detected until the line returns high and a new edge arrives.
REQ-032 Glitch and back-to-back:
- A low glitch of 4 clk cycles in IDLE produces busy for one half-bit and then IDLE, with no rx_valid.
- Two frames 7'h01 and 7'h7F sent with no idle gap produce 2 rx_valid pulses with the correct data.
REQ-033 Reset mid-frame: assert rst_n = 0 during data bit 3.
- Expected: all outputs go to 0 immediately and no rx_valid appears.
- A following clean frame 7'h2C is received correctly.
